vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator: horizontal/vertical counters with sync, blanking, data-enable and frame/line marker outputs, all registered and mutually aligned. Sits at the head of the video pipeline and feeds the pixel-drawing and VGA output stages. Supports any mode through parameters, programmable sync polarity, and a pixel clock enable for running from a faster system clock. Optional genlock input re-aligns the raster to an external frame pulse.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- CNT_W, 11, counter width
- clk  in  1  clock, posedge
- rst  in  1  reset, synchronous, active-high
- ce  in  1  pixel clock enable; raster advances only when high
- ext_sync  in  1  genlock frame pulse, clk-synchronous (present only with VGA_TIMING_GENLOCK_EN)
- hcount  out  CNT_W  pixel index in line
- vcount  out  CNT_W  line index in frame
- hsync  out  1  horizontal sync, HS_POL polarity
- vsync  out  1  vertical sync, VS_POL polarity
- hblnk  out  1  horizontal blanking
- vblnk  out  1  vertical blanking
- de  out  1  active video, = !hblnk & !vblnk
- sof  out  1  start of frame, high while at (0,0) after a wrap or genlock
- eol  out  1  end of line, high while hcount = H_TOTAL-1

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL likewise (default 628).
- Elaboration error if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CNT_W-1, or any porch/sync parameter is 0.
- On a clk edge with ce=1: hcount < H_TOTAL-1 -> hcount+1; else hcount=0 and vcount advances (vcount < V_TOTAL-1 -> +1, else 0).
- ce=0: every output holds.
- Decode is a function of the next counter values, registered with them, so all outputs describe the same pixel:
  - hblnk = hcount >= H_ACTIVE
  - hsync active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 840..967)
  - vblnk = vcount >= V_ACTIVE
  - vsync active when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default 601..604)
- sof is high on the first pixel of each frame entered by a wrap or genlock; eol is high on the last pixel of every line.
- Comparisons are unsigned at CNT_W bits; counters never exceed TOTAL-1.

## Timing
- Reset values: hcount=0, vcount=0, hsync=!HS_POL, vsync=!VS_POL, hblnk=0, vblnk=0, de=1, sof=0, eol=0, genlock pending=0.
- First ce after reset release moves to (1,0). Reset wins over ce and genlock on the same edge.
- Latency from counter state to decoded outputs: 0 (co-registered).
- Period: H_TOTAL ce-cycles per line, H_TOTAL*V_TOTAL per frame (default 663168).
- Reset mid-frame returns to the reset state in one edge, and the raster restarts from (0,0).

## Configuration
- VGA_TIMING_GENLOCK_EN defined:
  - ext_sync port exists. A 0->1 edge (registered edge detect, 1 clk latency) sets pending.
  - The next ce=1 edge loads (0,0) instead of incrementing, asserts sof, and clears pending.
  - An edge arriving while pending is already set is absorbed.
  - An edge that coincides with a natural wrap to (0,0) gives a single sof.
- VGA_TIMING_GENLOCK_EN undefined: no port and no edge logic; the raster free-runs.

## Test plan
- Defaults, ce=1 for 2 frames -> line period 1056 clk, frame period 663168; hsync=1 exactly for hcount 840..967; vsync=1 exactly for vcount 601..604; de=1 only for h<800 and v<600.
- rst held high, then released -> all outputs at their reset values; after 1 ce the counters read (1,0); after the wrap from (1055,627) sof=1 for one ce at (0,0).
- ce=1 one cycle in 4 -> identical sequence stretched 4x; all outputs stable on ce=0 cycles.
- HS_POL=0, VS_POL=0, mode 640x480 (16/96/48, 10/2/33) -> H_TOTAL 800, V_TOTAL 525; hsync low for hcount 656..751; vsync low for vcount 490..491.
- GENLOCK_EN: ext_sync pulsed at (300,200) -> within 2 ce counters reach (0,0) with sof=1; a second pulse before that ce gives no extra sof.
- rst asserted at (900,602) during vsync -> next cycle hsync=vsync inactive, counters at (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with co-registered sync/blank/de/sof/eol decode.
// Optional genlock to an external frame pulse when VGA_TIMING_GENLOCK_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
`ifdef VGA_TIMING_GENLOCK_EN
  input  logic             ext_sync,
`endif
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             sof,
  output logic             eol
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // Reject modes whose counters do not fit or that have an empty porch/sync interval
  if (((H_TOTAL - 1) >> CNT_W) != 32'd0) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
  end
  if (((V_TOTAL - 1) >> CNT_W) != 32'd0) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             de_q, de_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic             h_last_c, v_last_c, wrap_c, load_c;

  assign h_last_c = (hcount_q == CNT_W'(H_TOTAL - 1));
  assign v_last_c = (vcount_q == CNT_W'(V_TOTAL - 1));
  assign wrap_c   = h_last_c & v_last_c;

`ifdef VGA_TIMING_GENLOCK_EN
  logic sync_q;
  logic pending_q, pending_d;
  logic sync_edge_c;

  assign sync_edge_c = ext_sync & ~sync_q;
  assign load_c      = pending_q;

  // A pending request is consumed by the next ce; edges while pending or on a natural wrap are absorbed
  always_comb begin
    pending_d = pending_q;
    if (ce && pending_q) begin
      pending_d = 1'b0;
    end else if (sync_edge_c && !pending_q && !(ce && wrap_c)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= ext_sync;
      pending_q <= pending_d;
    end
  end
`else
  assign load_c = 1'b0;
`endif

  // Next counter values, then decode from them so every output describes the same pixel
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    sof_d    = sof_q;
    if (ce) begin
      sof_d = load_c | wrap_c;
      if (load_c) begin
        hcount_d = '0;
        vcount_d = '0;
      end else if (h_last_c) begin
        hcount_d = '0;
        vcount_d = v_last_c ? '0 : vcount_q + CNT_W'(1);
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end
    hblnk_d = (hcount_d >= CNT_W'(H_ACTIVE));
    vblnk_d = (vcount_d >= CNT_W'(V_ACTIVE));
    hsync_d = ((hcount_d >= CNT_W'(HS_START)) && (hcount_d < CNT_W'(HS_END))) ? HS_POL : ~HS_POL;
    vsync_d = ((vcount_d >= CNT_W'(VS_START)) && (vcount_d < CNT_W'(VS_END))) ? VS_POL : ~VS_POL;
    de_d    = ~hblnk_d & ~vblnk_d;
    eol_d   = (hcount_d == CNT_W'(H_TOTAL - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      de_q     <= 1'b1;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
    end else if (ce) begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      de_q     <= de_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
    end
  end

  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign hblnk  = hblnk_q;
  assign vblnk  = vblnk_q;
  assign de     = de_q;
  assign sof    = sof_q;
  assign eol    = eol_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: raster modelled as a linear pixel index within the frame.
module tb_vga_timing_gen;

  localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int unsigned VA = 10, VF = 1, VS = 2, VB = 3;
  localparam bit          HP = 1'b1, VP = 1'b0;
  localparam int unsigned CW = 5;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic hs, vs, hb, vb, de, sof, eol;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic ext_sync = 1'b0;
  logic [CW-1:0] hcount, vcount;
  logic hsync, vsync, hblnk, vblnk, de, sof, eol;

  int errors = 0;
  int checks = 0;
  obs_t exp_q[$];

  // Reference model state
  int unsigned m_p = 0;
  bit m_sof = 1'b0;
  bit m_pend = 1'b0;
  bit m_prev = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
`ifdef VGA_TIMING_GENLOCK_EN
    .ext_sync(ext_sync),
`endif
    .hcount(hcount),
    .vcount(vcount),
    .hsync(hsync),
    .vsync(vsync),
    .hblnk(hblnk),
    .vblnk(vblnk),
    .de(de),
    .sof(sof),
    .eol(eol)
  );

  function automatic obs_t expected();
    obs_t o;
    int unsigned h, v;
    h = m_p % HT;
    v = m_p / HT;
    o.h   = CW'(h);
    o.v   = CW'(v);
    o.hb  = (h >= HA);
    o.vb  = (v >= VA);
    o.hs  = (h >= HA + HF && h < HA + HF + HS) ? HP : !HP;
    o.vs  = (v >= VA + VF && v < VA + VF + VS) ? VP : !VP;
    o.de  = (h < HA) && (v < VA);
    o.sof = m_sof;
    o.eol = (h == HT - 1);
    return o;
  endfunction

  // One clock edge of the reference raster
  task automatic model_step(input bit r, input bit c, input bit e);
    bit rise, natural_wrap;
    rise = e && !m_prev;
    if (r) begin
      m_p = 0; m_sof = 1'b0; m_pend = 1'b0; m_prev = 1'b0;
      return;
    end
    natural_wrap = c && (m_p == FRAME - 1);
    if (c) begin
      if (m_pend) begin
        m_p = 0; m_sof = 1'b1; m_pend = 1'b0;
      end else begin
        m_p = (m_p + 1) % FRAME;
        m_sof = (m_p == 0);
        if (rise && !natural_wrap) m_pend = 1'b1;
      end
    end else if (rise) begin
      m_pend = 1'b1;
    end
    m_prev = e;
  endtask

  task automatic cyc(input bit r, input bit c, input bit e);
    @(negedge clk);
    rst = r; ce = c; ext_sync = e;
    @(posedge clk);
    model_step(r, c, e);
    exp_q.push_back(expected());
  endtask

  // Monitor: every edge the DUT presents a pixel; compare against the queued expectation
  always @(posedge clk) begin
    obs_t got, want;
    #1;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      got  = '{hcount, vcount, hsync, vsync, hblnk, vblnk, de, sof, eol};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL raster t=%0t got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b sof=%b eol=%b want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b sof=%b eol=%b",
                 $time, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.de, got.sof, got.eol,
                 want.h, want.v, want.hs, want.vs, want.hb, want.vb, want.de, want.sof, want.eol);
      end
    end
  end

  initial begin
    // Reset held with random ce
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    // Free run for over two frames
    for (int i = 0; i < 2 * FRAME + 50; i++) cyc(1'b0, 1'b1, 1'b0);
    // Pixel clock enable one cycle in four
    for (int i = 0; i < 4 * FRAME + 40; i++) cyc(1'b0, (i % 4) == 3, 1'b0);
    // Random ce with occasional reset
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 399) == 0, 1'($urandom_range(0, 1)), 1'b0);
    // Reset mid-frame while both syncs are active
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((m_p / HT) == VA + VF && (m_p % HT) == HA + HF + 1) break;
      cyc(1'b0, 1'b1, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 1'b0);
`ifdef VGA_TIMING_GENLOCK_EN
    // Genlock: isolated pulse, double pulse before the load ce, then random pulses
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++)
      cyc(1'b0, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
`endif
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
